// File: rtl/clk_pkg.sv
// ---------------------------------------------------------------------------
// clk_pkg
// Shared types and helpers for the timekeeping core and its display consumers.
//   time_t   : packed {hh[16:12], mm[11:6], ss[5:0]}, binary, 24h
//   edit_t   : edit state, also exported on edit_sel for blink indication
//   HH_MAX / MM_MAX / SS_MAX : field limits
//   stepHour / stepMinute    : wrap-around +1/-1 of an edited field
//   incTime  : advance a time value by one second with full carry chain
// ---------------------------------------------------------------------------
package clk_pkg;

    typedef struct packed {
        logic [4:0] hh;
        logic [5:0] mm;
        logic [5:0] ss;
    } time_t;

    typedef enum logic [2:0] {
        RUN      = 3'd0,
        SET_T_HH = 3'd1,
        SET_T_MM = 3'd2,
        SET_A_HH = 3'd3,
        SET_A_MM = 3'd4
    } edit_t;

    localparam logic [4:0] HH_MAX = 5'd23;
    localparam logic [5:0] MM_MAX = 6'd59;
    localparam logic [5:0] SS_MAX = 6'd59;

    // Hour field step: 23 wraps up to 0 and 0 wraps down to 23.
    function automatic logic [4:0] stepHour(input logic [4:0] value, input logic up);
        logic [4:0] result;
        if (up) begin
            result = (value == HH_MAX) ? 5'd0 : value + 5'd1;
        end else begin
            result = (value == 5'd0) ? HH_MAX : value - 5'd1;
        end
        return result;
    endfunction

    // Minute field step: 59 wraps up to 0 and 0 wraps down to 59.
    function automatic logic [5:0] stepMinute(input logic [5:0] value, input logic up);
        logic [5:0] result;
        if (up) begin
            result = (value == MM_MAX) ? 6'd0 : value + 6'd1;
        end else begin
            result = (value == 6'd0) ? MM_MAX : value - 6'd1;
        end
        return result;
    endfunction

    // One-second advance; 23:59:59 rolls over to 00:00:00.
    function automatic time_t incTime(input time_t t);
        time_t n;
        n = t;
        if (t.ss == SS_MAX) begin
            n.ss = 6'd0;
            if (t.mm == MM_MAX) begin
                n.mm = 6'd0;
                n.hh = (t.hh == HH_MAX) ? 5'd0 : t.hh + 5'd1;
            end else begin
                n.mm = t.mm + 6'd1;
            end
        end else begin
            n.ss = t.ss + 6'd1;
        end
        return n;
    endfunction

endpackage

// File: rtl/time_keeper_if.sv
// ---------------------------------------------------------------------------
// time_keeper_if
// User-control and display bundle of the timekeeping core.
//   i_btn_mode   1-cycle pulse, advances edit state
//   i_btn_up     1-cycle pulse, increments edited field
//   i_btn_down   1-cycle pulse, decrements edited field
//   i_alarm_en   level, alarm armed
//   i_alarm_ack  1-cycle pulse, silences alarm
//   o_disp_time  time_t shown on the display (alarm time while editing alarm)
//   o_alarm      alarm trigger to display
//   o_edit_sel   current edit state
// master: drives the buttons (user side); slave: the timekeeping core.
// ---------------------------------------------------------------------------
interface time_keeper_if;
    import clk_pkg::*;

    logic  i_btn_mode;
    logic  i_btn_up;
    logic  i_btn_down;
    logic  i_alarm_en;
    logic  i_alarm_ack;
    time_t o_disp_time;
    logic  o_alarm;
    edit_t o_edit_sel;

    modport master (
        output i_btn_mode, i_btn_up, i_btn_down, i_alarm_en, i_alarm_ack,
        input  o_disp_time, o_alarm, o_edit_sel
    );

    modport slave (
        input  i_btn_mode, i_btn_up, i_btn_down, i_alarm_en, i_alarm_ack,
        output o_disp_time, o_alarm, o_edit_sel
    );

endinterface

// File: rtl/tick_gen.sv
// ---------------------------------------------------------------------------
// tick_gen
// Prescaler producing the 1 s tick: counts 0..CLK_HZ-1, tick is the wrap.
//   clk      clock
//   reset    synchronous active-high reset (count to 0)
//   i_clear  force the count back to 0 on the next edge
//   i_hold   freeze the count and suppress the tick
//   o_tick   high for the one cycle whose edge wraps the count
// ---------------------------------------------------------------------------
module tick_gen #(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_hold,
    output logic o_tick
);

    localparam int            CW   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

    logic [CW-1:0] r_count;

    // The tick is decoded from the counter so the consumer can advance time on
    // the same edge the counter wraps.
    assign o_tick = (r_count == LAST) && !i_hold;

    // Prescaler counter; clear has priority over hold so entering a frozen
    // state always parks the count at 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear || o_tick) begin
            r_count <= '0;
        end else if (!i_hold) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/time_keeper.sv
// ---------------------------------------------------------------------------
// time_keeper
// 24h timekeeping and alarm core sitting directly upstream of the display.
//   clk     clock
//   reset   synchronous active-high reset, wins over everything
//   bus     time_keeper_if.slave: buttons, alarm_en/ack in; disp_time,
//           alarm, edit_sel out (all outputs registered)
// Parameters: CLK_HZ clock cycles per second, ALARM_SECS seconds the alarm
// stays high without an ack.
// ---------------------------------------------------------------------------
module time_keeper
    import clk_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int ALARM_SECS = 60
) (
    input  logic             clk,
    input  logic             reset,
    time_keeper_if.slave     bus
);

    localparam int            DW       = $clog2(ALARM_SECS + 1);
    localparam logic [DW-1:0] DUR_LAST = DW'(ALARM_SECS);

    edit_t         r_state;
    time_t         r_time;
    logic [4:0]    r_almHh;
    logic [5:0]    r_almMm;
    logic          r_alarm;
    logic [DW-1:0] r_dur;
    time_t         r_disp;

    logic          w_tick;
    logic          w_hold;
    logic          w_clear;
    logic          w_upOnly;
    logic          w_downOnly;
    logic          w_step;
    logic          w_enterSetT;
    logic          w_match;
    edit_t         w_stateNext;
    time_t         w_timeNext;
    logic [4:0]    w_almHhNext;
    logic [5:0]    w_almMmNext;
    logic          w_alarmNext;
    logic [DW-1:0] w_durNext;
    time_t         w_dispNext;

    // Mode wins over up/down, and up+down together cancel out.
    assign w_upOnly    = bus.i_btn_up && !bus.i_btn_down && !bus.i_btn_mode;
    assign w_downOnly  = bus.i_btn_down && !bus.i_btn_up && !bus.i_btn_mode;
    assign w_step      = w_upOnly || w_downOnly;
    assign w_enterSetT = (r_state == RUN) && bus.i_btn_mode;

    // Time is frozen while its fields are edited; the prescaler is parked at 0
    // on entry so counting resumes from a full second when editing ends.
    assign w_hold  = (r_state == SET_T_HH) || (r_state == SET_T_MM);
    assign w_clear = w_enterSetT;

    tick_gen #(
        .CLK_HZ (CLK_HZ)
    ) u_tickGen (
        .clk     (clk),
        .reset   (reset),
        .i_clear (w_clear),
        .i_hold  (w_hold),
        .o_tick  (w_tick)
    );

    // Next-state computation for every register, so the registered display
    // can show the value each register takes on this same edge.
    always_comb begin
        w_stateNext = r_state;
        w_timeNext  = r_time;
        w_almHhNext = r_almHh;
        w_almMmNext = r_almMm;
        w_alarmNext = r_alarm;
        w_durNext   = r_dur;
        w_match     = 1'b0;
        w_dispNext  = r_disp;

        if (bus.i_btn_mode) begin
            case (r_state)
                RUN:      w_stateNext = SET_T_HH;
                SET_T_HH: w_stateNext = SET_T_MM;
                SET_T_MM: w_stateNext = SET_A_HH;
                SET_A_HH: w_stateNext = SET_A_MM;
                default:  w_stateNext = RUN;
            endcase
        end

        if (w_tick) begin
            w_timeNext = incTime(r_time);
        end

        if (w_step) begin
            case (r_state)
                SET_T_HH: w_timeNext.hh = stepHour(r_time.hh, w_upOnly);
                SET_T_MM: w_timeNext.mm = stepMinute(r_time.mm, w_upOnly);
                SET_A_HH: w_almHhNext   = stepHour(r_almHh, w_upOnly);
                SET_A_MM: w_almMmNext   = stepMinute(r_almMm, w_upOnly);
                default:  ;
            endcase
        end

        // Seconds restart from zero once the new time has been entered.
        if ((r_state == SET_T_MM) && bus.i_btn_mode) begin
            w_timeNext.ss = 6'd0;
        end

        // Only a tick advance can produce a match, so reset to midnight never
        // fires an alarm set for 00:00.
        w_match = w_tick && !w_hold && bus.i_alarm_en &&
                  (w_timeNext.hh == r_almHh) && (w_timeNext.mm == r_almMm) &&
                  (w_timeNext.ss == 6'd0);

        // The duration counter reaches ALARM_SECS on the last tick, and the
        // alarm drops on the edge after that.
        if (w_enterSetT) begin
            w_alarmNext = 1'b0;
            w_durNext   = '0;
        end else if (r_alarm) begin
            if (bus.i_alarm_ack || !bus.i_alarm_en || (r_dur == DUR_LAST)) begin
                w_alarmNext = 1'b0;
                w_durNext   = '0;
            end else if (w_tick) begin
                w_durNext = r_dur + 1'b1;
            end
        end else if (w_match && !bus.i_alarm_ack) begin
            w_alarmNext = 1'b1;
            w_durNext   = '0;
        end

        if ((w_stateNext == SET_A_HH) || (w_stateNext == SET_A_MM)) begin
            w_dispNext = '{hh: w_almHhNext, mm: w_almMmNext, ss: 6'd0};
        end else begin
            w_dispNext = w_timeNext;
        end
    end

    // Edit FSM, counters, alarm and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RUN;
            r_time  <= '0;
            r_almHh <= '0;
            r_almMm <= '0;
            r_alarm <= 1'b0;
            r_dur   <= '0;
            r_disp  <= '0;
        end else begin
            r_state <= w_stateNext;
            r_time  <= w_timeNext;
            r_almHh <= w_almHhNext;
            r_almMm <= w_almMmNext;
            r_alarm <= w_alarmNext;
            r_dur   <= w_durNext;
            r_disp  <= w_dispNext;
        end
    end

    assign bus.o_disp_time = r_disp;
    assign bus.o_alarm     = r_alarm;
    assign bus.o_edit_sel  = r_state;

endmodule
